// File: rtl/bird_turn_sequencer.sv
// Turn/level game-flow controller for the bird launcher: one shot per turn, per-level bird budget,
// win/lose decision and level advance. Flags are registered decodes of the current state.
module bird_turn_sequencer #(
  parameter int unsigned NUM_BIRDS      = 3,
  parameter int unsigned NUM_LEVELS     = 3,
  parameter int unsigned FIRE_WAIT      = 4,
  parameter int unsigned FLIGHT_TIMEOUT = 300,
  parameter int unsigned SETTLE_FRAMES  = 30,
  parameter int unsigned END_FRAMES     = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       fire_req,
  input  logic       game_start,
  input  logic       bird_shoot,
  input  logic       all_pigs_dead,
  output logic       fire_bird,
  output logic       level_change,
  output logic [1:0] level_num,
  output logic [3:0] birds_left,
  output logic       level_won,
  output logic       game_over,
  output logic       game_won
);

  localparam int unsigned CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [3:0] {
    S_WAIT_START,
    S_LEVEL_LOAD,
    S_AIM,
    S_FIRE,
    S_FLIGHT,
    S_SETTLE,
    S_CHECK,
    S_LEVEL_CLEAR,
    S_GAME_OVER,
    S_GAME_WON
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_sof;
  logic             fire_d;
  logic             start_d;
  logic             fire_edge;
  logic             start_edge;
  logic             flight_timeout;
  logic             last_level;

  assign fire_edge      = fire_req & ~fire_d;
  assign start_edge     = game_start & ~start_d;
  // Frame counter advances on startOfFrame and saturates at its maximum.
  assign cnt_sof        = (startOfFrame && (cnt != CNT_MAX)) ? cnt + CNT_W'(1) : cnt;
  assign flight_timeout = (state == S_FLIGHT) && bird_shoot && (cnt == CNT_W'(FLIGHT_TIMEOUT));
  assign last_level     = (level_num == 2'(NUM_LEVELS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_WAIT_START;
      cnt          <= '0;
      fire_d       <= 1'b0;
      start_d      <= 1'b0;
      level_num    <= '0;
      birds_left   <= '0;
      fire_bird    <= 1'b0;
      level_change <= 1'b0;
      level_won    <= 1'b0;
      game_over    <= 1'b0;
      game_won     <= 1'b0;
    end else begin
      fire_d       <= fire_req;
      start_d      <= game_start;
      fire_bird    <= (state == S_FIRE);
      // A timed-out flight also reloads the level so the bird returns to the launcher.
      level_change <= (state == S_LEVEL_LOAD) || flight_timeout;
      level_won    <= (state == S_LEVEL_CLEAR);
      game_over    <= (state == S_GAME_OVER);
      game_won     <= (state == S_GAME_WON);

      case (state)
        S_WAIT_START: begin
          if (start_edge) begin
            state     <= S_LEVEL_LOAD;
            level_num <= '0;
            cnt       <= '0;
          end
        end
        S_LEVEL_LOAD: begin
          birds_left <= 4'(NUM_BIRDS);
          state      <= S_AIM;
          cnt        <= '0;
        end
        S_AIM: begin
          if (all_pigs_dead) begin
            state <= S_LEVEL_CLEAR;
            cnt   <= '0;
          end else if (fire_edge && (birds_left != '0)) begin
            state <= S_FIRE;
            cnt   <= '0;
          end
        end
        S_FIRE: begin
          if (bird_shoot) begin
            state <= S_FLIGHT;
            cnt   <= '0;
            if (birds_left != '0) birds_left <= birds_left - 4'd1;
          end else if (cnt == CNT_W'(FIRE_WAIT - 1)) begin
            state <= S_AIM;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_FLIGHT: begin
          if (!bird_shoot || flight_timeout) begin
            state <= S_SETTLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_sof;
          end
        end
        S_SETTLE: begin
          if (startOfFrame && (cnt == CNT_W'(SETTLE_FRAMES - 1))) begin
            state <= S_CHECK;
            cnt   <= '0;
          end else begin
            cnt <= cnt_sof;
          end
        end
        S_CHECK: begin
          cnt <= '0;
          if (all_pigs_dead)           state <= S_LEVEL_CLEAR;
          else if (birds_left == '0)   state <= S_GAME_OVER;
          else                         state <= S_AIM;
        end
        S_LEVEL_CLEAR: begin
          if (startOfFrame && (cnt == CNT_W'(END_FRAMES - 1))) begin
            cnt <= '0;
            if (last_level) begin
              state <= S_GAME_WON;
            end else begin
              level_num <= level_num + 2'd1;
              state     <= S_LEVEL_LOAD;
            end
          end else begin
            cnt <= cnt_sof;
          end
        end
        S_GAME_OVER, S_GAME_WON: begin
          if (start_edge) begin
            state     <= S_LEVEL_LOAD;
            level_num <= '0;
            cnt       <= '0;
          end
        end
        default: begin
          state <= S_WAIT_START;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bird_turn_sequencer.sv
// Directed bench for bird_turn_sequencer: a vector table for reset/start/first shot, then
// hand-written sequences for settle, game over, level advance, game won, timeout and mid-flight reset.
module tb_bird_turn_sequencer;

  typedef struct packed {
    logic reset;
    logic sof;
    logic fire_req;
    logic game_start;
    logic bird_shoot;
    logic all_pigs_dead;
  } in_t;

  typedef struct packed {
    logic       fire_bird;
    logic       level_change;
    logic [1:0] level_num;
    logic [3:0] birds_left;
    logic       level_won;
    logic       game_over;
    logic       game_won;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t e;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       startOfFrame;
  logic       fire_req;
  logic       game_start;
  logic       bird_shoot;
  logic       all_pigs_dead;
  logic       fire_bird;
  logic       level_change;
  logic [1:0] level_num;
  logic [3:0] birds_left;
  logic       level_won;
  logic       game_over;
  logic       game_won;
  out_t       act;

  int applied    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bird_turn_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .fire_req     (fire_req),
    .game_start   (game_start),
    .bird_shoot   (bird_shoot),
    .all_pigs_dead(all_pigs_dead),
    .fire_bird    (fire_bird),
    .level_change (level_change),
    .level_num    (level_num),
    .birds_left   (birds_left),
    .level_won    (level_won),
    .game_over    (game_over),
    .game_won     (game_won)
  );

  assign act = {fire_bird, level_change, level_num, birds_left, level_won, game_over, game_won};

  function automatic in_t mk(logic r, logic sof, logic f, logic g, logic s, logic p);
    mk = {r, sof, f, g, s, p};
  endfunction

  function automatic out_t ex(logic fb, logic lc, int ln, int bl, logic lw, logic go, logic gw);
    ex = {fb, lc, 2'(ln), 4'(bl), lw, go, gw};
  endfunction

  task automatic drive(input in_t i);
    {reset, startOfFrame, fire_req, game_start, bird_shoot, all_pigs_dead} = i;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input in_t i, input out_t e, input string tag);
    drive(i);
    applied++;
    if (act !== e) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b [fb lc ln bl lw go gw]", tag, act, e);
    end
  endtask

  task automatic run_frames(input int n, input in_t base);
    in_t b;
    b = base;
    for (int k = 0; k < n; k++) begin
      b.sof = 1'b1;
      drive(b);
      b.sof = 1'b0;
      drive(b);
    end
  endtask

  // Fire, bird leaves two clocks after the key edge, lands one clock later; ends in SETTLE.
  task automatic shot(input int ln, input int bl_before, input string tag);
    apply(mk(0,0,1,0,0,0), ex(0,0,ln,bl_before,0,0,0), {tag, "_press"});
    apply(mk(0,0,0,0,0,0), ex(1,0,ln,bl_before,0,0,0), {tag, "_fire"});
    apply(mk(0,0,0,0,1,0), ex(1,0,ln,bl_before-1,0,0,0), {tag, "_launch"});
    apply(mk(0,0,0,0,1,0), ex(0,0,ln,bl_before-1,0,0,0), {tag, "_flight"});
    apply(mk(0,0,0,0,0,0), ex(0,0,ln,bl_before-1,0,0,0), {tag, "_land"});
  endtask

  vec_t tbl[13];
  in_t  idle;
  in_t  pigs;

  initial begin
    idle = mk(0,0,0,0,0,0);
    pigs = mk(0,0,0,0,0,1);
    {reset, startOfFrame, fire_req, game_start, bird_shoot, all_pigs_dead} = mk(1,0,0,0,0,0);

    tbl[0]  = {mk(1,0,0,0,0,0), ex(0,0,0,0,0,0,0)};
    tbl[1]  = {mk(1,0,0,0,0,0), ex(0,0,0,0,0,0,0)};
    tbl[2]  = {mk(0,0,0,0,0,0), ex(0,0,0,0,0,0,0)};
    tbl[3]  = {mk(0,0,1,0,0,0), ex(0,0,0,0,0,0,0)};
    tbl[4]  = {mk(0,0,0,1,0,0), ex(0,0,0,0,0,0,0)};
    tbl[5]  = {mk(0,0,0,0,0,0), ex(0,1,0,3,0,0,0)};
    tbl[6]  = {mk(0,0,0,0,0,0), ex(0,0,0,3,0,0,0)};
    tbl[7]  = {mk(0,0,0,1,0,0), ex(0,0,0,3,0,0,0)};
    tbl[8]  = {mk(0,0,1,0,0,0), ex(0,0,0,3,0,0,0)};
    tbl[9]  = {mk(0,0,0,0,0,0), ex(1,0,0,3,0,0,0)};
    tbl[10] = {mk(0,0,0,0,1,0), ex(1,0,0,2,0,0,0)};
    tbl[11] = {mk(0,0,0,0,1,0), ex(0,0,0,2,0,0,0)};
    tbl[12] = {mk(0,0,0,0,0,0), ex(0,0,0,2,0,0,0)};

    for (int k = 0; k < 13; k++) begin
      apply(tbl[k].i, tbl[k].e, $sformatf("vec%0d", k));
    end

    // Settle: a fire edge two clocks after the 29th frame must still be ignored.
    run_frames(28, idle);
    apply(mk(0,1,0,0,0,0), ex(0,0,0,2,0,0,0), "settle_f29");
    apply(idle, ex(0,0,0,2,0,0,0), "settle_gap0");
    apply(idle, ex(0,0,0,2,0,0,0), "settle_gap1");
    apply(mk(0,0,1,0,0,0), ex(0,0,0,2,0,0,0), "settle_fire_press");
    apply(idle, ex(0,0,0,2,0,0,0), "settle_fire_ignored0");
    apply(idle, ex(0,0,0,2,0,0,0), "settle_fire_ignored1");
    apply(mk(0,1,0,0,0,0), ex(0,0,0,2,0,0,0), "settle_f30");
    apply(idle, ex(0,0,0,2,0,0,0), "check_to_aim");

    // No bird_shoot: fire_bird held exactly 4 clocks, no bird consumed.
    apply(mk(0,0,1,0,0,0), ex(0,0,0,2,0,0,0), "noshoot_press");
    for (int k = 0; k < 4; k++) apply(idle, ex(1,0,0,2,0,0,0), $sformatf("noshoot_hold%0d", k));
    apply(idle, ex(0,0,0,2,0,0,0), "noshoot_drop");

    // Remaining two birds spent with pigs alive -> game over; fire then ignored.
    shot(0, 2, "shot2");
    run_frames(30, idle);
    shot(0, 1, "shot3");
    run_frames(30, idle);
    apply(idle, ex(0,0,0,0,0,1,0), "game_over");
    apply(mk(0,0,1,0,0,0), ex(0,0,0,0,0,1,0), "go_fire_press");
    apply(idle, ex(0,0,0,0,0,1,0), "go_no_fire0");
    apply(idle, ex(0,0,0,0,0,1,0), "go_no_fire1");

    // Restart, clear level 0 through CHECK.
    apply(mk(0,0,0,1,0,0), ex(0,0,0,0,0,1,0), "restart_edge");
    apply(idle, ex(0,1,0,3,0,0,0), "restart_load");
    shot(0, 3, "l0shot");
    run_frames(29, pigs);
    apply(mk(0,1,0,0,0,1), ex(0,0,0,2,0,0,0), "l0_settle_f30");
    apply(pigs, ex(0,0,0,2,0,0,0), "l0_check");
    apply(pigs, ex(0,0,0,2,1,0,0), "l0_won");
    run_frames(89, pigs);
    apply(mk(0,1,0,0,0,0), ex(0,0,1,2,1,0,0), "l0_end_f90");
    apply(idle, ex(0,1,1,3,0,0,0), "l1_load");
    apply(idle, ex(0,0,1,3,0,0,0), "l1_aim");

    // Level 1 cleared directly from AIM.
    apply(pigs, ex(0,0,1,3,0,0,0), "l1_aim_clear");
    apply(pigs, ex(0,0,1,3,1,0,0), "l1_won");
    run_frames(89, pigs);
    apply(mk(0,1,0,0,0,0), ex(0,0,2,3,1,0,0), "l1_end_f90");
    apply(idle, ex(0,1,2,3,0,0,0), "l2_load");
    apply(idle, ex(0,0,2,3,0,0,0), "l2_aim");

    // Last level cleared -> game won, level_num stays at 2.
    apply(pigs, ex(0,0,2,3,0,0,0), "l2_aim_clear");
    apply(pigs, ex(0,0,2,3,1,0,0), "l2_won");
    run_frames(89, pigs);
    apply(mk(0,1,0,0,0,0), ex(0,0,2,3,1,0,0), "l2_end_f90");
    apply(idle, ex(0,0,2,3,0,0,1), "game_won");
    apply(mk(0,0,0,1,0,0), ex(0,0,0,3,0,0,1), "gw_restart_edge");
    apply(idle, ex(0,1,0,3,0,0,0), "gw_restart_load");

    // Bird never lands: forced end after FLIGHT_TIMEOUT frames with a level_change pulse.
    apply(mk(0,0,1,0,0,0), ex(0,0,0,3,0,0,0), "to_press");
    apply(idle, ex(1,0,0,3,0,0,0), "to_fire");
    apply(mk(0,0,0,0,1,0), ex(1,0,0,2,0,0,0), "to_launch");
    run_frames(299, mk(0,0,0,0,1,0));
    apply(mk(0,1,0,0,1,0), ex(0,0,0,2,0,0,0), "to_f300");
    apply(mk(0,0,0,0,1,0), ex(0,1,0,2,0,0,0), "to_pulse");
    apply(idle, ex(0,0,0,2,0,0,0), "to_pulse_end");
    run_frames(30, idle);

    // Reset while in flight.
    apply(mk(0,0,1,0,0,0), ex(0,0,0,2,0,0,0), "rst_press");
    apply(idle, ex(1,0,0,2,0,0,0), "rst_fire");
    apply(mk(0,0,0,0,1,0), ex(1,0,0,1,0,0,0), "rst_launch");
    apply(mk(1,0,0,0,1,0), ex(0,0,0,0,0,0,0), "rst_in_flight");
    apply(idle, ex(0,0,0,0,0,0,0), "rst_release");
    apply(mk(0,0,1,0,0,0), ex(0,0,0,0,0,0,0), "rst_fire_press");
    apply(idle, ex(0,0,0,0,0,0,0), "rst_wait_start0");
    apply(idle, ex(0,0,0,0,0,0,0), "rst_wait_start1");

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
